// File: rtl/dsm_bitstream_decoder_pkg.sv
// Shared delta-sigma defaults and decoder types.
// The DAC-side encoder and this decoder both take their widths from here so
// that the two ends of a DSM link always agree on sample width and window.
package dsm_bitstream_decoder_pkg;

  // Width of one reconstructed (or encoded) sample.
  localparam int DSM_DATA_WIDTH = 4;

  // Decimation window is 2^DSM_OSR_LOG2 bitstream bits; must be >= DSM_DATA_WIDTH.
  localparam int DSM_OSR_LOG2   = 4;

  // What the output register does on a given clock edge.
  typedef enum logic [1:0] {
    OUT_HOLD      = 2'd0,  // keep data and valid as they are
    OUT_LOAD      = 2'd1,  // window closed, slot free or being drained: load new sample
    OUT_OVERWRITE = 2'd2,  // window closed onto an unconsumed sample: replace it, flag overrun
    OUT_CONSUME   = 2'd3   // consumer took the sample, nothing new arriving
  } out_action_e;

endpackage : dsm_bitstream_decoder_pkg

// File: rtl/dsm_bitstream_decoder_window.sv
// dsm_window_counter: counts strobed bitstream bits over a window of
// 2^OSR_LOG2 strobes and reports the ones total on the closing strobe.
// The closing strobe's own bit is folded into the total combinationally, and
// the counter/accumulator restart on that same edge, so back-to-back windows
// never drop a strobe.
module dsm_window_counter
  import dsm_bitstream_decoder_pkg::*;
#(
  parameter int OSR_LOG2 = DSM_OSR_LOG2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sample,
  input  logic                i_dsm_bit,
  output logic                o_close,
  output logic [OSR_LOG2:0]   o_total
);

  localparam logic [OSR_LOG2-1:0] LP_LAST = '1;
  localparam logic [OSR_LOG2-1:0] LP_ONE  = {{(OSR_LOG2-1){1'b0}}, 1'b1};

  logic [OSR_LOG2-1:0] r_bit_cnt;
  logic [OSR_LOG2:0]   r_acc;

  logic                w_last;
  logic [OSR_LOG2:0]   w_total;

  // Window close is the strobe that lands on the last count; total includes that bit.
  always_comb begin
    w_last  = (r_bit_cnt == LP_LAST);
    w_total = r_acc + {{OSR_LOG2{1'b0}}, i_dsm_bit};
  end

  // Count strobes and accumulate ones; restart both at window close.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_acc     <= '0;
    end else if (i_sample) begin
      r_bit_cnt <= r_bit_cnt + LP_ONE;
      if (w_last) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_total;
      end
    end
  end

  assign o_close = i_sample && w_last;
  assign o_total = w_total;

endmodule : dsm_window_counter

// File: rtl/dsm_bitstream_decoder.sv
// dsm_bitstream_decoder: decimating decoder for a first-order delta-sigma
// bitstream. The window counter produces a ones total every 2^OSR_LOG2
// strobes; this top scales it to DATA_WIDTH bits (saturating all-ones rather
// than wrapping), holds it in a single-entry output register and runs a
// valid/ready handshake with a one-cycle overrun pulse when an unconsumed
// sample is replaced.
// OSR_LOG2 must be >= DATA_WIDTH.
module dsm_bitstream_decoder
  import dsm_bitstream_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = DSM_DATA_WIDTH,
  parameter int OSR_LOG2   = DSM_OSR_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sample,
  input  logic                  i_dsm_bit,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overrun
);

  localparam int                LP_SHIFT   = OSR_LOG2 - DATA_WIDTH;
  localparam logic [OSR_LOG2:0] LP_MAX_EXT =
    {{(OSR_LOG2 + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  // Scale a window total down to DATA_WIDTH bits. A window of all ones gives
  // 2^OSR_LOG2, which after the shift is one past full scale; clamp it so it
  // reads as maximum instead of wrapping to zero.
  function automatic logic [DATA_WIDTH-1:0] sat_result(input logic [OSR_LOG2:0] total);
    logic [OSR_LOG2:0] shifted;
    shifted = total >> LP_SHIFT;
    if (shifted > LP_MAX_EXT) begin
      return {DATA_WIDTH{1'b1}};
    end
    return shifted[DATA_WIDTH-1:0];
  endfunction

  logic                  w_close_p0;
  logic [OSR_LOG2:0]     w_total_p0;
  logic [DATA_WIDTH-1:0] w_result_p0;
  out_action_e           w_action;

  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_vld_p1;
  logic                  r_ovr_p1;

  dsm_window_counter #(
    .OSR_LOG2 (OSR_LOG2)
  ) u_window (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sample  (i_sample),
    .i_dsm_bit (i_dsm_bit),
    .o_close   (w_close_p0),
    .o_total   (w_total_p0)
  );

  // Stage p0 -> p1: window close result enters the output register.
  // Decide the output register action from close strobe and handshake state.
  always_comb begin
    w_result_p0 = sat_result(w_total_p0);
    w_action    = OUT_HOLD;
    if (w_close_p0) begin
      if (r_vld_p1 && !i_ready) begin
        w_action = OUT_OVERWRITE;
      end else begin
        w_action = OUT_LOAD;
      end
    end else if (r_vld_p1 && i_ready) begin
      w_action = OUT_CONSUME;
    end
  end

  // Output register and handshake; overrun is a single-cycle pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_ovr_p1  <= 1'b0;
    end else begin
      unique case (w_action)
        OUT_LOAD: begin
          r_data_p1 <= w_result_p0;
          r_vld_p1  <= 1'b1;
          r_ovr_p1  <= 1'b0;
        end
        OUT_OVERWRITE: begin
          r_data_p1 <= w_result_p0;
          r_vld_p1  <= 1'b1;
          r_ovr_p1  <= 1'b1;
        end
        OUT_CONSUME: begin
          r_vld_p1  <= 1'b0;
          r_ovr_p1  <= 1'b0;
        end
        default: begin
          r_ovr_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data    = r_data_p1;
  assign o_valid   = r_vld_p1;
  assign o_overrun = r_ovr_p1;

endmodule : dsm_bitstream_decoder

// File: tb/tb_dsm_bitstream_decoder.sv
// Bench for dsm_bitstream_decoder at default widths: table of full windows
// with known answers, hand sequences for overrun / coincident handshake /
// mid-window reset / DAC loopback, then random traffic against a
// window-level reference model.
module tb_dsm_bitstream_decoder;

  localparam int DATA_WIDTH = 4;
  localparam int OSR_LOG2   = 4;
  localparam int WIN        = 1 << OSR_LOG2;
  localparam int DMAX       = (1 << DATA_WIDTH) - 1;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_sample;
  logic                  i_dsm_bit;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_overrun;

  dsm_bitstream_decoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .OSR_LOG2   (OSR_LOG2)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sample  (i_sample),
    .i_dsm_bit (i_dsm_bit),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_overrun (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits of the open window, plus the output slot.
  bit win_q[$];
  int m_data  = 0;
  bit m_valid = 0;
  bit m_ovr   = 0;

  typedef struct {
    string       name;
    logic [15:0] bits;
    int          gap_max;
    int          exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int window_value();
    int ones = 0;
    int r;
    foreach (win_q[k]) ones += int'(win_q[k]);
    r = ones >> (OSR_LOG2 - DATA_WIDTH);
    if (r > DMAX) r = DMAX;
    return r;
  endfunction

  task automatic model_reset();
    win_q.delete();
    m_data  = 0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, settle.
  task automatic step(input logic s, input logic b, input logic r);
    bit close;
    int v;
    i_sample  = s;
    i_dsm_bit = b;
    i_ready   = r;
    @(posedge i_clk);
    close = 0;
    v     = 0;
    if (s) begin
      win_q.push_back(b);
      if (win_q.size() == WIN) begin
        close = 1;
        v     = window_value();
        win_q.delete();
      end
    end
    if (close) begin
      m_ovr   = m_valid && !r;
      m_valid = 1;
      m_data  = v;
    end else begin
      m_ovr = 0;
      if (m_valid && r) m_valid = 0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"},   {31'd0, o_valid},   {31'd0, m_valid});
    chk({tag, " data"},    {28'd0, o_data},    m_data);
    chk({tag, " overrun"}, {31'd0, o_overrun}, {31'd0, m_ovr});
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_model("drain");
  endtask

  // Sixteen strobes with random idle gaps; idle cycles carry junk bits.
  task automatic apply_window(input logic [15:0] bits, input int gap_max,
                              input logic rdy, input bit chk_early);
    for (int i = 0; i < WIN; i++) begin
      int g;
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
        step(1'b0, 1'($urandom_range(1, 0)), rdy);
        check_model("gap");
      end
      step(1'b1, bits[i], rdy);
      check_model("strobe");
      if (chk_early && i < WIN - 1) chk("no early valid", {31'd0, o_valid}, 32'd0);
    end
  endtask

  initial begin
    int dac_acc;
    logic [15:0] dbits;

    vecs[0] = '{"all zeros",       16'h0000, 0, 0};
    vecs[1] = '{"all ones sat",    16'hFFFF, 0, 15};
    vecs[2] = '{"alt 1010 gaps",   16'h5555, 3, 8};
    vecs[3] = '{"four ones",       16'h000F, 1, 4};
    vecs[4] = '{"fifteen ones",    16'h7FFF, 2, 15};
    vecs[5] = '{"first bit only",  16'h0001, 1, 1};
    vecs[6] = '{"closing bit only",16'h8000, 2, 1};

    i_rst_n   = 1'b0;
    i_sample  = 1'b0;
    i_dsm_bit = 1'b0;
    i_ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset data",    {28'd0, o_data},    32'd0);
    chk("reset valid",   {31'd0, o_valid},   32'd0);
    chk("reset overrun", {31'd0, o_overrun}, 32'd0);
    i_rst_n = 1'b1;

    // Table of full windows, consumer stalled so the result is held.
    foreach (vecs[v]) begin
      drain();
      apply_window(vecs[v].bits, vecs[v].gap_max, 1'b0, 1'b1);
      chk({vecs[v].name, " valid"}, {31'd0, o_valid}, 32'd1);
      chk({vecs[v].name, " data"},  {28'd0, o_data},  vecs[v].exp_data);
      step(1'b0, 1'b0, 1'b0);
      chk({vecs[v].name, " held"},  {28'd0, o_data},  vecs[v].exp_data);
    end

    // Two windows with consumer stalled: overrun only at the second close.
    drain();
    apply_window(16'h001F, 1, 1'b0, 1'b1);
    chk("ovr win1 data",    {28'd0, o_data},    32'd5);
    chk("ovr win1 overrun", {31'd0, o_overrun}, 32'd0);
    apply_window(16'h01FF, 1, 1'b0, 1'b0);
    chk("ovr win2 overrun", {31'd0, o_overrun}, 32'd1);
    chk("ovr win2 data",    {28'd0, o_data},    32'd9);
    chk("ovr win2 valid",   {31'd0, o_valid},   32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("ovr pulse ends",   {31'd0, o_overrun}, 32'd0);
    chk("ovr data held",    {28'd0, o_data},    32'd9);

    // Window close coinciding with a consume: valid stays high, no overrun.
    drain();
    apply_window(16'h0003, 0, 1'b0, 1'b1);
    chk("coinc first data", {28'd0, o_data}, 32'd2);
    for (int i = 0; i < WIN - 1; i++) step(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_model("coinc");
    chk("coinc valid",   {31'd0, o_valid},   32'd1);
    chk("coinc overrun", {31'd0, o_overrun}, 32'd0);
    chk("coinc data",    {28'd0, o_data},    32'd3);
    step(1'b0, 1'b0, 1'b1);
    chk("coinc consumed", {31'd0, o_valid}, 32'd0);

    // Reset partway through a window discards it.
    drain();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst data",  {28'd0, o_data},  32'd0);
    chk("midrst valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    apply_window(16'h0000, 0, 1'b0, 1'b1);
    chk("post-reset valid", {31'd0, o_valid}, 32'd1);
    chk("post-reset data",  {28'd0, o_data},  32'd0);

    // Loopback from a first-order DSM DAC driven with constant 5.
    drain();
    dac_acc = 0;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < WIN; i++) begin
        dac_acc += 5;
        if (dac_acc >= WIN) begin
          dbits[i] = 1'b1;
          dac_acc -= WIN;
        end else begin
          dbits[i] = 1'b0;
        end
      end
      apply_window(dbits, 2, 1'b1, 1'b0);
      chk("loop valid", {31'd0, o_valid}, 32'd1);
      n_tests++;
      if (!(o_data inside {4'd4, 4'd5, 4'd6})) begin
        n_fail++;
        $display("FAIL loop range: got %0d, expected 4..6", o_data);
      end
      if (w > 0) chk("loop settled", {28'd0, o_data}, 32'd5);
    end

    // Random traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           ($urandom_range(2, 0) == 0) ? 1'b1 : 1'b0);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dsm_bitstream_decoder

// File: doc/dsm_bitstream_decoder.md
DSM_BITSTREAM_DECODER -- requirements
Module: dsm_bitstream_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, giving the width of the reconstructed output sample.
REQ-002 SHALL have parameter OSR_LOG2, default 4, giving the decimation window as 2^OSR_LOG2 bits; OSR_LOG2 >= DATA_WIDTH.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sample  input  1  bit strobe; i_dsm_bit is consumed only when high.
REQ-006 SHALL have port i_dsm_bit  input  1  delta-sigma bitstream input.
REQ-007 SHALL have port o_data  output  DATA_WIDTH  decoded sample.
REQ-008 SHALL have port o_valid  output  1  o_data holds an unconsumed sample.
REQ-009 SHALL have port i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse when an unconsumed sample is overwritten.

Function
REQ-011 SHALL keep a bit counter of OSR_LOG2 bits and a ones accumulator of OSR_LOG2+1 bits, both changing only on cycles with i_sample high.
REQ-012 SHALL, on each i_sample, add i_dsm_bit to the accumulator and increment the bit counter modulo 2^OSR_LOG2.
REQ-013 SHALL treat the strobe on which the bit counter equals 2^OSR_LOG2-1 as window close: total = accumulator + i_dsm_bit, including the current bit.
REQ-014 SHALL compute result = total >> (OSR_LOG2-DATA_WIDTH), clamped to 2^DATA_WIDTH-1 when total = 2^OSR_LOG2, i.e. all ones saturates and does not wrap to 0.
REQ-015 SHALL, at window close, load result into o_data, clear the accumulator to 0 and wrap the bit counter to 0 in the same edge; no strobe is lost between windows.
REQ-016 SHALL assert o_valid in the cycle after the window-close strobe (latency 1 clock).
REQ-017 SHALL clear o_valid on the edge after a cycle with o_valid && i_ready and no simultaneous window close.
REQ-018 SHALL, when window close coincides with o_valid && i_ready, load the new result and keep o_valid high; o_overrun stays low.
REQ-019 SHALL, when window close occurs with o_valid high and i_ready low, overwrite o_data, keep o_valid high and pulse o_overrun high for exactly one cycle.
REQ-020 SHALL hold o_data stable while o_valid is high and no window close occurs, regardless of i_ready.
REQ-021 SHALL hold all state on cycles with i_sample low; gaps between strobes of any length are legal.

Reset
REQ-022 SHALL, on i_rst_n low, asynchronously clear the bit counter, accumulator, o_data, o_valid and o_overrun to 0.
REQ-023 SHALL discard a partial window on reset mid-operation; the first window after release spans a full 2^OSR_LOG2 strobes.
REQ-024 SHALL accept strobes on the first rising edge after i_rst_n deasserts.

Structure
REQ-025 SHALL take default DATA_WIDTH and OSR_LOG2 values from the shared DSM defines header used by the DAC-side blocks, so encoder and decoder widths match.
REQ-026 SHALL place counting and window close in one sub-module, dsm_window_counter (outputs: window-close strobe, total); the top holds the output register and handshake.

Verification
REQ-027 SHALL verify, with defaults, 16 strobes of bit 0 -> o_data=0, o_valid high 1 cycle after the 16th strobe.
REQ-028 SHALL verify 16 strobes of bit 1 -> o_data=15 (saturated), not 0.
REQ-029 SHALL verify 16 strobes of pattern 1,0,1,0... with random i_sample gaps -> o_data=8.
REQ-030 SHALL verify that with i_ready low for two windows (5 ones, then 9 ones), o_overrun pulses once at the second close and o_data=9 with o_valid high.
REQ-031 SHALL verify reset after 7 strobes of bit 1, then 16 strobes of bit 0 -> o_data=0, with no result before the 16th strobe.
REQ-032 SHALL verify loopback from the team's first-order DSM DAC at constant input 5, strobed identically: every decoded sample is in {4,5,6}, and all samples after the first window equal 5.
